// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, status bit positions, widths and FSM states for the ALU sequencer
package alu_pkg;

  localparam int ALU_WORD_W = 20;
  localparam int ALU_REG_AW = 4;

  localparam int SR_ZERO  = 0;
  localparam int SR_CARRY = 1;
  localparam int SR_SIGN  = 2;

  typedef enum logic [4:0] {
    OP_NOP, OP_TRAP, OP_JMP, OP_JZ, OP_JS, OP_JZS, OP_LDSR, OP_XORSR,
    OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
    OP_SWAP, OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
    OP_EQ, OP_GT, OP_LT, OP_GE, OP_LE
  } opcode_e;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_WB_A, S_WB_B, S_TRAP} state_e;

  function automatic logic is_jump(input logic [4:0] op);
    return op inside {OP_JMP, OP_JZ, OP_JS, OP_JZS};
  endfunction

  // Codes above OP_LE have no meaning and halt the controller just like TRAP.
  function automatic logic is_trap(input logic [4:0] op);
    return op == OP_TRAP || op > OP_LE;
  endfunction

  // These finish in EXEC: they only touch status (or nothing) and never write back.
  function automatic logic is_no_wb(input logic [4:0] op);
    return op inside {OP_NOP, OP_LDSR, OP_XORSR, OP_EQ, OP_GT, OP_LT, OP_GE, OP_LE};
  endfunction

endpackage

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: combinational logic/shift/arithmetic/compare function with status update
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WORD_W = ALU_WORD_W
) (
  input  logic [4:0]        op,
  input  logic              mode,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [2:0]        status_in,
  output logic [WORD_W-1:0] result,
  output logic [WORD_W-1:0] result2,
  output logic [2:0]        status_out
);

  localparam int H = WORD_W / 2;
  localparam logic [WORD_W-1:0] HALF_MASK = {{(WORD_W-H){1'b0}}, {H{1'b1}}};
  localparam logic [WORD_W:0]   ONE       = {{WORD_W{1'b0}}, 1'b1};

  logic [WORD_W-1:0] mask, am, bm, top_m;
  logic [WORD_W:0]   x;
  logic              cin, top, cy, upd, arith;
  logic [2:0]        st;

  // In half-word mode everything works on a 10-bit word living in the low bits.
  assign mask  = mode ? '1 : HALF_MASK;
  assign am    = a & mask;
  assign bm    = b & mask;
  assign top_m = mode ? {1'b1, {(WORD_W-1){1'b0}}} : {{(WORD_W-H){1'b0}}, 1'b1, {(H-1){1'b0}}};
  assign top   = |(am & top_m);
  assign cin   = status_in[SR_CARRY];

  // x carries one extra bit so the carry/borrow of either width can be picked off it.
  always_comb begin
    x       = '0;
    result2 = '0;
    cy      = cin;
    upd     = 1'b1;
    arith   = 1'b0;
    st      = status_in;
    case (op)
      OP_NOT:  x = {1'b0, ~am};
      OP_AND:  x = {1'b0, am & bm};
      OP_OR:   x = {1'b0, am | bm};
      OP_XOR:  x = {1'b0, am ^ bm};
      OP_SHR:  begin x = {1'b0, am >> 1}; cy = am[0]; end
      OP_SHL:  begin x = {1'b0, am << 1}; cy = top; end
      OP_ROR:  x = {1'b0, (am >> 1) | (am[0] ? top_m : '0)};
      OP_ROL:  x = {1'b0, (am << 1) | {{(WORD_W-1){1'b0}}, top}};
      OP_SWAP: begin x = {1'b0, bm}; result2 = am; end
      OP_INC:  begin x = {1'b0, am} + ONE; arith = 1'b1; end
      OP_DEC:  begin x = {1'b0, am} - ONE; arith = 1'b1; end
      OP_ADD:  begin x = {1'b0, am} + {1'b0, bm}; arith = 1'b1; end
      OP_ADC:  begin x = {1'b0, am} + {1'b0, bm} + {{WORD_W{1'b0}}, cin}; arith = 1'b1; end
      OP_SUB:  begin x = {1'b0, am} - {1'b0, bm}; arith = 1'b1; end
      OP_SBC:  begin x = {1'b0, am} - {1'b0, bm} - {{WORD_W{1'b0}}, cin}; arith = 1'b1; end
      OP_EQ:   begin upd = 1'b0; st[SR_ZERO] = am == bm; st[SR_SIGN] = 1'b0; end
      OP_GT:   begin upd = 1'b0; st[SR_SIGN] = am > bm;  st[SR_ZERO] = 1'b0; end
      OP_LT:   begin upd = 1'b0; st[SR_SIGN] = am < bm;  st[SR_ZERO] = 1'b0; end
      OP_GE:   begin upd = 1'b0; st[SR_SIGN] = am >= bm; st[SR_ZERO] = am == bm; end
      OP_LE:   begin upd = 1'b0; st[SR_SIGN] = am <= bm; st[SR_ZERO] = am == bm; end
      OP_LDSR: begin upd = 1'b0; st = a[2:0]; end
      OP_XORSR: begin upd = 1'b0; st = status_in ^ a[2:0]; end
      default: upd = 1'b0;
    endcase
    if (arith) cy = mode ? x[WORD_W] : x[H];
    result     = x[WORD_W-1:0] & mask;
    status_out = upd ? {mode ? result[WORD_W-1] : result[H-1], cy, ~|result} : st;
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: issue/exec/writeback sequencer with status register; ALU_RETIRE_CNT_EN adds retire_cnt
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WORD_W = ALU_WORD_W,
  parameter int REG_AW = ALU_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [4:0]        issue_op,
  input  logic              issue_mode,
  input  logic [WORD_W-1:0] issue_a,
  input  logic [WORD_W-1:0] issue_b,
  input  logic [REG_AW-1:0] issue_dst_a,
  input  logic [REG_AW-1:0] issue_dst_b,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [WORD_W-1:0] wb_data,
  output logic [2:0]        status,
  output logic              pc_load,
  output logic [WORD_W-1:0] pc_target,
  output logic              trapped
`ifdef ALU_RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  state_e            state, nxt;
  logic [4:0]        op_q;
  logic              mode_q, jump, cond;
  logic [WORD_W-1:0] a_q, b_q, res_q, res2_q, result, result2;
  logic [REG_AW-1:0] dst_a_q, dst_b_q;
  logic [2:0]        status_nxt;

  alu_exec_unit #(.WORD_W(WORD_W)) u_exec (
    .op        (op_q),
    .mode      (mode_q),
    .a         (a_q),
    .b         (b_q),
    .status_in (status),
    .result    (result),
    .result2   (result2),
    .status_out(status_nxt)
  );

  // State register; instruction latched on the handshake, results and status on EXEC exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dst_a_q <= '0;
      dst_b_q <= '0;
      res_q   <= '0;
      res2_q  <= '0;
      status  <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && issue_valid) begin
        op_q    <= issue_op;
        mode_q  <= issue_mode;
        a_q     <= issue_a;
        b_q     <= issue_b;
        dst_a_q <= issue_dst_a;
        dst_b_q <= issue_dst_b;
      end
      if (state == S_EXEC) begin
        res_q  <= result;
        res2_q <= result2;
        status <= status_nxt;
      end
    end
  end

  // Next state and per-state outputs; write and jump buses read zero when not strobed.
  always_comb begin
    nxt         = state;
    jump        = is_jump(op_q);
    cond        = op_q == OP_JMP ? 1'b1 :
                  op_q == OP_JZ  ? status[SR_ZERO] :
                  op_q == OP_JS  ? status[SR_SIGN] : status[SR_ZERO] & status[SR_SIGN];
    issue_ready = state == S_IDLE;
    trapped     = state == S_TRAP;
    wb_valid    = (state == S_WB_A && !jump) || state == S_WB_B;
    wb_addr     = state == S_WB_B ? dst_b_q : wb_valid ? dst_a_q : '0;
    wb_data     = state == S_WB_B ? res2_q : wb_valid ? res_q : '0;
    pc_load     = state == S_WB_A && jump && cond;
    pc_target   = pc_load ? b_q : '0;
    case (state)
      S_IDLE:  nxt = issue_valid ? S_EXEC : S_IDLE;
      S_EXEC:  nxt = is_trap(op_q) ? S_TRAP : is_no_wb(op_q) ? S_IDLE : S_WB_A;
      S_WB_A:  nxt = op_q == OP_SWAP ? S_WB_B : S_IDLE;
      S_WB_B:  nxt = S_IDLE;
      default: nxt = S_TRAP;
    endcase
  end

`ifdef ALU_RETIRE_CNT_EN
  // Count instructions retiring out of EXEC (SWAP once, traps never), saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt <= '0;
    else if (state == S_EXEC && !is_trap(op_q) && retire_cnt != 16'hFFFF) retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed scoreboard bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_op = '0;
  logic        issue_mode = 1'b0;
  logic [19:0] issue_a = '0;
  logic [19:0] issue_b = '0;
  logic [3:0]  issue_dst_a = '0;
  logic [3:0]  issue_dst_b = '0;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [19:0] wb_data;
  logic [2:0]  status;
  logic        pc_load;
  logic [19:0] pc_target;
  logic        trapped;

  alu_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_op   (issue_op),
    .issue_mode (issue_mode),
    .issue_a    (issue_a),
    .issue_b    (issue_b),
    .issue_dst_a(issue_dst_a),
    .issue_dst_b(issue_dst_b),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .status     (status),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .trapped    (trapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [19:0] data;
    logic [2:0]  st;
    bit          cst;
  } wb_t;

  wb_t         wbq[$];
  logic [19:0] pcq[$];
  wb_t         e;
  logic [19:0] pe;
  int          passed = 0;
  int          failed = 0;
  int          total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_wb(input logic [3:0] addr, input logic [19:0] data, input logic [2:0] st, input bit cst);
    wb_t w;
    w.addr = addr;
    w.data = data;
    w.st   = st;
    w.cst  = cst;
    wbq.push_back(w);
  endtask

  // Issue one instruction, then measure cycles from the handshake edge until ready returns.
  task automatic issue(input logic [4:0] op, input logic mode, input logic [19:0] a, input logic [19:0] b,
                       input logic [3:0] da, input logic [3:0] db, input int lat, input string tag);
    int k;
    @(negedge clk);
    issue_op = op;
    issue_mode = mode;
    issue_a = a;
    issue_b = b;
    issue_dst_a = da;
    issue_dst_b = db;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    k = 1;
    if (lat == 0) return;
    while (!issue_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, lat);
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (wbq.size() == 0) begin
        total++;
        failed++;
        $error("FAIL wb_unexpected observed addr=%h data=%h expected no write", wb_addr, wb_data);
      end else begin
        e = wbq.pop_front();
        chk("wb_addr", {28'b0, wb_addr}, {28'b0, e.addr});
        chk("wb_data", {12'b0, wb_data}, {12'b0, e.data});
        if (e.cst) chk("wb_status", {29'b0, status}, {29'b0, e.st});
      end
    end
    if (rst_n && pc_load) begin
      if (pcq.size() == 0) begin
        total++;
        failed++;
        $error("FAIL pc_unexpected observed target=%h expected no jump", pc_target);
      end else begin
        pe = pcq.pop_front();
        chk("pc_target", {12'b0, pc_target}, {12'b0, pe});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, issue_ready}, 32'd1);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_addr", {28'b0, wb_addr}, 32'd0);
    chk("rst_wb_data", {12'b0, wb_data}, 32'd0);
    chk("rst_status", {29'b0, status}, 32'd0);
    chk("rst_pc", {31'b0, pc_load}, 32'd0);
    chk("rst_trapped", {31'b0, trapped}, 32'd0);

    push_wb(4'd5, 20'h00007, 3'b000, 1);
    issue(5'd19, 1'b1, 20'h00003, 20'h00004, 4'd5, 4'd0, 3, "add");
    push_wb(4'd3, 20'h00000, 3'b011, 1);
    issue(5'd19, 1'b1, 20'hFFFFF, 20'h00001, 4'd3, 4'd0, 3, "add_wrap");
    push_wb(4'd4, 20'h00001, 3'b000, 1);
    issue(5'd20, 1'b1, 20'h00000, 20'h00000, 4'd4, 4'd0, 3, "adc");
    push_wb(4'd6, 20'h00000, 3'b011, 1);
    issue(5'd17, 1'b0, 20'h003FF, 20'h00000, 4'd6, 4'd0, 3, "inc_half");
    push_wb(4'd7, 20'hFFFFF, 3'b110, 1);
    issue(5'd21, 1'b1, 20'h00000, 20'h00001, 4'd7, 4'd0, 3, "sub_borrow");
    push_wb(4'd8, 20'h00002, 3'b010, 1);
    issue(5'd13, 1'b0, 20'h00201, 20'h00000, 4'd8, 4'd0, 3, "shl_half");
    push_wb(4'd9, 20'h80000, 3'b110, 1);
    issue(5'd14, 1'b1, 20'h00001, 20'h00000, 4'd9, 4'd0, 3, "ror");
    push_wb(4'd1, 20'h0ABCD, 3'b000, 0);
    push_wb(4'd2, 20'h12345, 3'b000, 0);
    issue(5'd16, 1'b1, 20'h12345, 20'h0ABCD, 4'd1, 4'd2, 4, "swap");
    issue(5'd25, 1'b1, 20'h00002, 20'h00009, 4'd0, 4'd0, 2, "lt");
    chk("lt_status", {29'b0, status}, {29'b0, 3'b110});
    pcq.push_back(20'h00100);
    issue(5'd4, 1'b1, 20'h00000, 20'h00100, 4'd0, 4'd0, 3, "js");
    chk("js_status", {29'b0, status}, {29'b0, 3'b110});

    issue(5'd30, 1'b1, 20'h00000, 20'h00000, 4'd0, 4'd0, 0, "illegal");
    issue_valid = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      bad = bad | !trapped | issue_ready;
    end
    chk("trap_hold", {31'b0, bad}, 32'd0);
    issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("trap_rst_trapped", {31'b0, trapped}, 32'd0);
    chk("trap_rst_ready", {31'b0, issue_ready}, 32'd1);
    chk("trap_rst_status", {29'b0, status}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push_wb(4'd10, 20'h00002, 3'b000, 1);
    issue(5'd19, 1'b1, 20'h00001, 20'h00001, 4'd10, 4'd0, 3, "add_after_rst");

    @(negedge clk);
    issue_op = 5'd19;
    issue_mode = 1'b1;
    issue_a = 20'h00005;
    issue_b = 20'h00005;
    issue_dst_a = 4'd11;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_ready", {31'b0, issue_ready}, 32'd1);
    chk("wbq_empty", wbq.size(), 32'd0);
    chk("pcq_empty", pcq.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
